// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with start/done handshake and three-state FSM.
// Define ALU_MULDIV_EN to build the iterative MULT/DIV/MOD engine (ITER state).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       ALU_sel,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] operation_result,
  output logic [6:0]       Flags,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int MSB = WIDTH - 1;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_MULT = 8'h05;
  localparam logic [7:0] OP_DIV  = 8'h06;
  localparam logic [7:0] OP_MOD  = 8'h07;
  localparam logic [7:0] OP_AND  = 8'h08;
  localparam logic [7:0] OP_OR   = 8'h09;
  localparam logic [7:0] OP_NOT  = 8'h0A;
  localparam logic [7:0] OP_NOR  = 8'h0D;
  localparam logic [7:0] OP_NAND = 8'h0E;
  localparam logic [7:0] OP_XNOR = 8'h0F;
  localparam logic [7:0] OP_INC  = 8'h10;
  localparam logic [7:0] OP_XOR  = 8'h11;
  localparam logic [7:0] OP_DEC  = 8'h12;
  localparam logic [7:0] OP_SL   = 8'h14;
  localparam logic [7:0] OP_SR   = 8'h15;
  localparam logic [7:0] OP_ROL  = 8'h16;
  localparam logic [7:0] OP_ROR  = 8'h17;
  localparam logic [7:0] OP_CMP  = 8'h18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
    S_ITER = 2'd2,
`endif
    S_EXEC = 2'd1
  } state_t;

  function automatic logic f_even_parity(input logic [WIDTH-1:0] v);
    return ~^v;
  endfunction

  state_t           r_state, w_next;
  logic [7:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_busy, r_done, r_eq, r_gt, r_lt;
  logic [WIDTH-1:0] r_result;
  logic [6:0]       r_flags;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_add, w_sub;
  logic             w_c, w_v, w_d, w_cmp, w_z, w_s, w_p;
  logic             w_accept, w_finish;
  logic [6:0]       w_flags;

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  function automatic logic f_is_muldiv(input logic [7:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  logic [WIDTH-1:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sum, w_rem_sh, w_diff;
  logic             w_iter_last;

  assign w_iter_last = (r_state == S_ITER) && (r_cnt == CW'(WIDTH));
  assign w_finish    = (r_state == S_EXEC) || w_iter_last;

  // One shift-add (MULT) or restoring-divide (DIV/MOD) step; hi:lo is product or remainder:quotient.
  always_comb begin
    w_sum    = {1'b0, r_hi} + {1'b0, r_a};
    w_rem_sh = {r_hi, r_lo[MSB]};
    w_diff   = w_rem_sh - {1'b0, r_b};
    if (r_op == OP_MULT) begin
      if (r_lo[0]) begin
        {w_hi_nxt, w_lo_nxt} = {w_sum, r_lo[MSB:1]};
      end else begin
        {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[MSB:1]};
      end
    end else if (!w_diff[WIDTH]) begin
      w_hi_nxt = w_diff[MSB:0];
      w_lo_nxt = {r_lo[MSB-1:0], 1'b1};
    end else begin
      w_hi_nxt = w_rem_sh[MSB:0];
      w_lo_nxt = {r_lo[MSB-1:0], 1'b0};
    end
  end
`else
  assign w_finish = (r_state == S_EXEC);
`endif

  assign w_accept = (r_state == S_IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MULDIV_EN
          w_next = f_is_muldiv(ALU_sel) ? S_ITER : S_EXEC;
`else
          w_next = S_EXEC;
`endif
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC: w_next = S_IDLE;
`ifdef ALU_MULDIV_EN
      S_ITER: begin
        if (w_iter_last) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_ITER;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};

  // Output logic: result and op-specific C/V/D for the latched operation.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_d   = 1'b0;
    w_cmp = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[WIDTH];
        w_v   = (r_a[MSB] == r_b[MSB]) && (w_add[MSB] != r_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[WIDTH];
        w_v   = (r_a[MSB] != r_b[MSB]) && (w_sub[MSB] != r_a[MSB]);
        w_cmp = (r_op == OP_CMP);
      end
`ifdef ALU_MULDIV_EN
      OP_MULT: begin
        w_res = r_lo;
        w_c   = |r_hi;
        w_v   = |r_hi;
      end
      OP_DIV: begin
        if (r_b == '0) begin
          w_res = '1;
          w_v   = 1'b1;
        end else begin
          w_res = r_lo;
        end
      end
      OP_MOD: begin
        if (r_b == '0) begin
          w_res = r_a;
          w_v   = 1'b1;
        end else begin
          w_res = r_hi;
        end
      end
`endif
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_NOT:  w_res = ~r_a;
      OP_NOR:  w_res = ~(r_a | r_b);
      OP_NAND: w_res = ~(r_a & r_b);
      OP_XNOR: w_res = ~(r_a ^ r_b);
      OP_XOR:  w_res = r_a ^ r_b;
      OP_INC: begin
        w_res = r_a + WIDTH'(1);
        w_c   = &r_a;
        w_v   = ~r_a[MSB] & w_res[MSB];
      end
      OP_DEC: begin
        w_res = r_a - WIDTH'(1);
        w_c   = ~|r_a;
        w_v   = r_a[MSB] & ~w_res[MSB];
      end
      OP_SL: begin
        w_res = {r_a[MSB-1:0], 1'b0};
        w_c   = r_a[MSB];
        w_v   = r_a[MSB] ^ r_a[MSB-1];
        w_d   = 1'b1;
      end
      OP_SR: begin
        w_res = {1'b0, r_a[MSB:1]};
        w_c   = r_a[0];
      end
      OP_ROL: begin
        w_res = {r_a[MSB-1:0], r_a[MSB]};
        w_c   = r_a[MSB];
      end
      OP_ROR: begin
        w_res = {r_a[0], r_a[MSB:1]};
        w_c   = r_a[0];
      end
      default: w_res = '0;
    endcase
  end

  assign w_z     = (w_res == '0);
  assign w_s     = w_res[MSB];
  assign w_p     = f_even_parity(w_res);
  assign w_flags = {w_v, w_d, 1'b0, w_p, w_s, w_c, w_z};

  // Operand latch, iteration engine and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= 7'd0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
      r_op     <= 8'd0;
      r_a      <= '0;
      r_b      <= '0;
`ifdef ALU_MULDIV_EN
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_finish) begin
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_result <= w_res;
        r_flags  <= w_flags;
        r_eq     <= w_cmp & w_z;
        r_gt     <= w_cmp & ~w_z & (w_s == w_v);
        r_lt     <= w_cmp & (w_s ^ w_v);
      end else if (w_accept) begin
        r_busy <= 1'b1;
        r_op   <= ALU_sel;
        r_a    <= operand1;
        r_b    <= operand2;
`ifdef ALU_MULDIV_EN
        r_hi   <= '0;
        r_lo   <= (ALU_sel == OP_MULT) ? operand2 : operand1;
        r_cnt  <= '0;
      end else if (r_state == S_ITER) begin
        r_hi   <= w_hi_nxt;
        r_lo   <= w_lo_nxt;
        r_cnt  <= r_cnt + CW'(1);
`endif
      end
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign operation_result = r_result;
  assign Flags            = r_flags;
  assign eq               = r_eq;
  assign gt               = r_gt;
  assign lt               = r_lt;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq (WIDTH = 8); expectations follow ALU_MULDIV_EN.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [7:0]   ALU_sel;
  logic [W-1:0] operand1, operand2;
  logic         busy, done, eq, gt, lt;
  logic [W-1:0] operation_result;
  logic [6:0]   Flags;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] res;
    logic [6:0] flags;
    logic [2:0] cmp;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_sel(ALU_sel),
    .operand1(operand1), .operand2(operand2),
    .busy(busy), .done(done), .operation_result(operation_result),
    .Flags(Flags), .eq(eq), .gt(gt), .lt(lt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cmp is {eq,gt,lt}; poke raises start again while the op is still in flight
  task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res, input logic [6:0] fl,
                        input logic [2:0] cmp, input int lat, input bit poke);
    exp_t e;
    int   n;
    bit   busy_ok;
    ALU_sel = op; operand1 = a; operand2 = b; start = 1'b1;
    sb.push_back('{res, fl, cmp, lat});
    @(posedge clk); #1;
    start = 1'b0;
    ALU_sel = 8'($urandom); operand1 = 8'($urandom); operand2 = 8'($urandom);
    chk({tag, ":busy_start"}, 32'(busy), 32'd1);
    n = 0; busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (poke && n == 0) begin
        start = 1'b1; ALU_sel = 8'h03;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (!done) busy_ok &= busy;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, ":done"}, 32'(done), 32'd1);
    chk({tag, ":latency"}, 32'(n), 32'(e.lat));
    chk({tag, ":result"}, 32'(operation_result), 32'(e.res));
    chk({tag, ":flags"}, 32'(Flags), 32'(e.flags));
    chk({tag, ":eq_gt_lt"}, 32'({eq, gt, lt}), 32'(e.cmp));
    chk({tag, ":busy_end"}, 32'(busy), 32'd0);
    chk({tag, ":busy_hold"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic idle_hold(input string tag, input logic [7:0] res);
    @(posedge clk); #1;
    chk({tag, ":done_low"}, 32'(done), 32'd0);
    chk({tag, ":busy_low"}, 32'(busy), 32'd0);
    chk({tag, ":result_hold"}, 32'(operation_result), 32'(res));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ":busy"}, 32'(busy), 32'd0);
    chk({tag, ":done"}, 32'(done), 32'd0);
    chk({tag, ":result"}, 32'(operation_result), 32'd0);
    chk({tag, ":flags"}, 32'(Flags), 32'd0);
    chk({tag, ":eq_gt_lt"}, 32'({eq, gt, lt}), 32'd0);
  endtask

  initial begin
    bit any_done;
    rst = 1'b1; start = 1'b0; ALU_sel = 8'h00; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    rst = 1'b0;

    run_op("add_ovf",  8'h03, 8'h7F, 8'h01, 8'h80, 7'h44, 3'b000, 1, 1'b0);
    idle_hold("add_hold", 8'h80);
    run_op("cmp_gt",   8'h18, 8'h05, 8'hFB, 8'h0A, 7'h0A, 3'b010, 1, 1'b0);
    run_op("cmp_lt",   8'h18, 8'hFB, 8'h05, 8'hF6, 7'h0C, 3'b001, 1, 1'b0);
    run_op("cmp_eq",   8'h18, 8'h33, 8'h33, 8'h00, 7'h09, 3'b100, 1, 1'b0);
    run_op("and_clr",  8'h08, 8'h0F, 8'h3C, 8'h0C, 7'h08, 3'b000, 1, 1'b0);
    run_op("sub_brw",  8'h04, 8'h05, 8'h07, 8'hFE, 7'h06, 3'b000, 1, 1'b0);
    run_op("add_cry",  8'h03, 8'hFF, 8'h01, 8'h00, 7'h0B, 3'b000, 1, 1'b0);
    run_op("sl",       8'h14, 8'h81, 8'h00, 8'h02, 7'h62, 3'b000, 1, 1'b0);
    run_op("sr",       8'h15, 8'h81, 8'h00, 8'h40, 7'h02, 3'b000, 1, 1'b0);
    run_op("rol",      8'h16, 8'h81, 8'h00, 8'h03, 7'h0A, 3'b000, 1, 1'b0);
    run_op("ror",      8'h17, 8'h81, 8'h00, 8'hC0, 7'h0E, 3'b000, 1, 1'b0);
    run_op("inc_wrap", 8'h10, 8'hFF, 8'h00, 8'h00, 7'h0B, 3'b000, 1, 1'b0);
    run_op("inc_ovf",  8'h10, 8'h7F, 8'h00, 8'h80, 7'h44, 3'b000, 1, 1'b0);
    run_op("dec_ovf",  8'h12, 8'h80, 8'h00, 8'h7F, 7'h40, 3'b000, 1, 1'b0);
    run_op("dec_wrap", 8'h12, 8'h00, 8'h00, 8'hFF, 7'h0E, 3'b000, 1, 1'b0);
    run_op("xor",      8'h11, 8'hA5, 8'hFF, 8'h5A, 7'h08, 3'b000, 1, 1'b0);
    run_op("not",      8'h0A, 8'h0F, 8'h00, 8'hF0, 7'h0C, 3'b000, 1, 1'b0);
    run_op("nor",      8'h0D, 8'h0F, 8'hF0, 8'h00, 7'h09, 3'b000, 1, 1'b0);
    run_op("nand",     8'h0E, 8'hF0, 8'h3C, 8'hCF, 7'h0C, 3'b000, 1, 1'b0);
    run_op("or",       8'h09, 8'h01, 8'h02, 8'h03, 7'h08, 3'b000, 1, 1'b0);
    run_op("xnor",     8'h0F, 8'h0F, 8'h0F, 8'hFF, 7'h0C, 3'b000, 1, 1'b0);
    run_op("illegal",  8'h00, 8'h12, 8'h34, 8'h00, 7'h09, 3'b000, 1, 1'b1);
    idle_hold("illegal_poke", 8'h00);

`ifdef ALU_MULDIV_EN
    run_op("mult",     8'h05, 8'h03, 8'h04, 8'h0C, 7'h08, 3'b000, W + 1, 1'b0);
    run_op("mult_hi",  8'h05, 8'h10, 8'h10, 8'h00, 7'h4B, 3'b000, W + 1, 1'b0);
    run_op("div",      8'h06, 8'hC8, 8'h07, 8'h1C, 7'h00, 3'b000, W + 1, 1'b0);
    run_op("mod_b2b",  8'h07, 8'hC8, 8'h07, 8'h04, 7'h00, 3'b000, W + 1, 1'b0);
    run_op("div0",     8'h06, 8'h55, 8'h00, 8'hFF, 7'h4C, 3'b000, W + 1, 1'b1);
    idle_hold("div0_poke", 8'hFF);
    run_op("mod0",     8'h07, 8'h55, 8'h00, 8'h55, 7'h48, 3'b000, W + 1, 1'b0);

    // abort an in-flight DIV with reset at edge 4
    ALU_sel = 8'h06; operand1 = 8'hC8; operand2 = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_cleared("abort");
    any_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      any_done |= done;
    end
    chk("abort:no_done", 32'(any_done), 32'd0);
`else
    run_op("mult_ill", 8'h05, 8'h03, 8'h04, 8'h00, 7'h09, 3'b000, 1, 1'b0);
    run_op("div_ill",  8'h06, 8'hC8, 8'h07, 8'h00, 7'h09, 3'b000, 1, 1'b0);
    run_op("mod_ill",  8'h07, 8'hC8, 8'h07, 8'h00, 7'h09, 3'b000, 1, 1'b0);
`endif

    run_op("add_pre",  8'h03, 8'h7F, 8'h01, 8'h80, 7'h44, 3'b000, 1, 1'b0);
    // rst and start together: rst wins
    ALU_sel = 8'h03; operand1 = 8'h01; operand2 = 8'h01; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk_cleared("rst_start");
    @(posedge clk); #1;
    chk("rst_start:no_done", 32'(done), 32'd0);
    chk("rst_start:no_busy", 32'(busy), 32'd0);
    run_op("or_after", 8'h09, 8'h01, 8'h02, 8'h03, 7'h08, 3'b000, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
